mul_ctrl: RTL and testbench
===========================

Name: mul_ctrl

Overview:
- Sequencing controller for the iterative 32x32 Multiplier used by the execute stage for RV32M MUL/MULH/MULHSU/MULHU.
- Accepts one request at a time from execute, converts signed operands to magnitudes, pulses Run on the multiplier and waits for ready.
- On completion it applies the sign correction, selects the high or low word and returns a single-cycle response.
- A one-entry product cache lets a MULH/MUL pair on identical operands skip the second multiply.

Parameters:
- WIDTH, 32, operand/result width (XLEN); product is 2*WIDTH.
- CACHE_EN, 1, 1 = product cache enabled, 0 = every request runs the multiplier.

Ports:
- Clk  in  1  clock, all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset; same Reset also drives the attached Multiplier.
- req_valid  in  1  execute presents a multiply request.
- req_ready  out  1  controller accepts the request this cycle.
- req_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- req_rs1  in  WIDTH  operand A.
- req_rs2  in  WIDTH  operand B.
- flush  in  1  kill any in-flight or same-cycle request.
- resp_valid  out  1  one-cycle pulse, resp_data valid.
- resp_data  out  WIDTH  result word.
- mul_run  out  1  start pulse to Multiplier Run.
- mul_a  out  WIDTH  unsigned magnitude of A to multiplier.
- mul_b  out  WIDTH  unsigned magnitude of B to multiplier.
- mul_ready  in  1  multiplier result-valid pulse.
- mul_hi  in  WIDTH  product bits [2W-1:W] (multiplier Aval).
- mul_lo  in  WIDTH  product bits [W-1:0] (multiplier Bval).

Behaviour:
- Multiplier contract:
  - It forms the unsigned product of mul_a and mul_b.
  - mul_a and mul_b are held stable from the mul_run cycle until mul_ready.
  - mul_ready arrives at least 1 cycle after mul_run.
- Reset values: state IDLE, req_ready 0 during Reset, resp_valid 0, resp_data 0, mul_run 0, mul_a/mul_b 0, cache invalid.
- States: IDLE, START, WAIT, FIX, DRAIN.
- Handshake:
  - req_ready = (state==IDLE) & ~flush & ~Reset.
  - A request is accepted when req_valid & req_ready; operands, op and sign flags are latched.
- Signedness:
  - sA = rs1[W-1] for ops 00/01/10.
  - sB = rs2[W-1] for ops 00/01.
  - Otherwise the sign flag is 0.
  - Magnitude = sign ? -x : x (0x80000000 maps to 0x80000000 unsigned).
  - neg = sA ^ sB.
- Cache hit, checked in the accept cycle:
  - Requires CACHE_EN, cache valid, rs1 and rs2 equal to the cached operands, and (req_op==cached op OR req_op==00).
  - Result comes from the cached 64-bit product.
  - resp_valid at accept+1; no mul_run; state stays IDLE.
- Miss path:
  - IDLE->START on accept.
  - START: mul_run=1 for exactly one cycle; drive magnitudes; go to WAIT.
  - WAIT: on mul_ready, latch {mul_hi,mul_lo}; go to FIX.
  - FIX: product = neg ? two's-complement negate (2W bits) : raw. Write cache (operands, op, product, valid=1). Register resp_data = op==00 ? product[W-1:0] : product[2W-1:W]. Go to IDLE.
  - resp_valid pulses in the cycle after FIX, which is also the first cycle req_ready is high again.
- Latency:
  - Hit: 1 cycle.
  - Miss: mul_ready cycle R gives resp_valid at R+2.
- flush:
  - Takes priority over req_valid in the same cycle; the request is not accepted.
  - In START: mul_run is not issued; go to IDLE.
  - In WAIT: go to DRAIN; wait for mul_ready, discard the product, go to IDLE. req_ready stays 0 throughout.
  - In FIX: no response, no cache write; go to IDLE.
  - Flush never invalidates an already-valid cache entry.
- Flush in the same cycle as mul_ready in WAIT: product discarded, go to IDLE.
- Reset mid-operation: immediate return to IDLE, all outputs at reset values, cache invalid, no response issued.
- resp_valid is never asserted twice for one accepted request, and never for a flushed request.

Test Plan:
- MULH rs1=0xFFFFFFF6 (-10), rs2=12:
  - mul_a=10, mul_b=12, one mul_run pulse.
  - resp_data=0xFFFFFFFF at mul_ready+2.
- MUL with the same operands immediately after: cache hit, no mul_run, resp_data=0xFFFFFF88 one cycle after accept.
- MULHU rs1=0xFFFFFFF6, rs2=12: miss (op differs), mul_a=0xFFFFFFF6, resp_data=0x0000000B.
- Signed and mixed-sign cases:
  - MULHSU rs1=0xFFFFFFF6, rs2=0x80000000 gives resp_data=0xFFFFFFFB.
  - MULH rs1=rs2=0x80000000 gives resp_data=0x40000000.
- Flush during WAIT:
  - req_ready stays 0 until the late mul_ready.
  - No resp_valid; the next MUL 3x5 returns 0x0000000F.
- Reset asserted in WAIT:
  - Next cycle all outputs are 0 and state is IDLE.
  - A subsequent repeat of an earlier request misses the cache (mul_run pulses).

Source files
------------

// File: rtl/mul_ctrl_if.sv
// Bundle of the execute-side request/response handshake and the
// controller-to-multiplier bus. The controller uses the slave view; the
// execute stage and the multiplier together form the master view.
interface mul_ctrl_if #(
  parameter int WIDTH = 32
);
  // Request from execute
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [WIDTH-1:0] req_rs1;
  logic [WIDTH-1:0] req_rs2;
  logic             flush;

  // Response to execute
  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;

  // Multiplier bus
  logic             mul_run;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] mul_b;
  logic             mul_ready;
  logic [WIDTH-1:0] mul_hi;
  logic [WIDTH-1:0] mul_lo;

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, flush,
    input  mul_ready, mul_hi, mul_lo,
    output req_ready, resp_valid, resp_data,
    output mul_run, mul_a, mul_b
  );

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, flush,
    output mul_ready, mul_hi, mul_lo,
    input  req_ready, resp_valid, resp_data,
    input  mul_run, mul_a, mul_b
  );
endinterface

// File: rtl/mul_ctrl.sv
// Sequencing controller for an iterative unsigned WIDTHxWIDTH multiplier.
// Handles RV32M MUL/MULH/MULHSU/MULHU: converts signed operands to
// magnitudes, runs the multiplier, restores the sign, picks the word and
// returns a one-cycle response. A one-entry product cache lets a MUL that
// follows a high-word op on the same operands (or an exact repeat) skip the
// multiplier entirely.
module mul_ctrl #(
  parameter int WIDTH    = 32,
  parameter int CACHE_EN = 1
) (
  input  logic      Clk,
  input  logic      Reset,
  mul_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT,
    FIX,
    DRAIN
  } state_t;

  localparam logic [1:0] OP_MUL = 2'b00;

  state_t             state;

  // Latched request
  logic [1:0]         op_q;
  logic [WIDTH-1:0]   rs1_q;
  logic [WIDTH-1:0]   rs2_q;
  logic               sign_a_q;
  logic               sign_b_q;

  // Raw unsigned product captured from the multiplier
  logic [2*WIDTH-1:0] prod_q;

  // One-entry product cache
  logic               cache_valid;
  logic [1:0]         cache_op;
  logic [WIDTH-1:0]   cache_rs1;
  logic [WIDTH-1:0]   cache_rs2;
  logic [2*WIDTH-1:0] cache_prod;

  // Registered outputs
  logic               resp_valid_q;
  logic [WIDTH-1:0]   resp_data_q;
  logic               mul_run_q;
  logic [WIDTH-1:0]   mul_a_q;
  logic [WIDTH-1:0]   mul_b_q;

  // Combinational helpers
  logic               accept;
  logic               req_sign_a;
  logic               req_sign_b;
  logic               cache_hit;
  logic [WIDTH-1:0]   hit_word;
  logic [WIDTH-1:0]   mag_a;
  logic [WIDTH-1:0]   mag_b;
  logic               neg;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   fix_word;

  // Ready only in IDLE; flush and reset both block acceptance in the same cycle
  assign bus.req_ready  = (state == IDLE) & ~bus.flush & ~Reset;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.mul_run    = mul_run_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;

  // Request decode, cache lookup, magnitude conversion and sign correction
  always_comb begin
    accept     = bus.req_valid & bus.req_ready;
    req_sign_a = bus.req_rs1[WIDTH-1] & (bus.req_op != 2'b11);
    req_sign_b = bus.req_rs2[WIDTH-1] & ~bus.req_op[1];
    // A MUL only needs the low word, which is identical for every op flavour
    cache_hit  = (CACHE_EN != 0) & cache_valid
               & (bus.req_rs1 == cache_rs1) & (bus.req_rs2 == cache_rs2)
               & ((bus.req_op == cache_op) | (bus.req_op == OP_MUL));
    hit_word   = (bus.req_op == OP_MUL) ? cache_prod[WIDTH-1:0]
                                        : cache_prod[2*WIDTH-1:WIDTH];
    // The most negative value negates to itself, which is its correct magnitude
    mag_a      = sign_a_q ? -rs1_q : rs1_q;
    mag_b      = sign_b_q ? -rs2_q : rs2_q;
    neg        = sign_a_q ^ sign_b_q;
    prod_fix   = neg ? -prod_q : prod_q;
    fix_word   = (op_q == OP_MUL) ? prod_fix[WIDTH-1:0]
                                  : prod_fix[2*WIDTH-1:WIDTH];
  end

  // Controller FSM with all outputs and the cache registered
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      op_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      sign_a_q     <= 1'b0;
      sign_b_q     <= 1'b0;
      prod_q       <= '0;
      cache_valid  <= 1'b0;
      cache_op     <= '0;
      cache_rs1    <= '0;
      cache_rs2    <= '0;
      cache_prod   <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      mul_run_q    <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      mul_run_q    <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (cache_hit) begin
              resp_valid_q <= 1'b1;
              resp_data_q  <= hit_word;
            end else begin
              op_q     <= bus.req_op;
              rs1_q    <= bus.req_rs1;
              rs2_q    <= bus.req_rs2;
              sign_a_q <= req_sign_a;
              sign_b_q <= req_sign_b;
              state    <= START;
            end
          end
        end
        START: begin
          if (bus.flush) begin
            state <= IDLE;
          end else begin
            mul_run_q <= 1'b1;
            mul_a_q   <= mag_a;
            mul_b_q   <= mag_b;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (bus.mul_ready) begin
            if (bus.flush) begin
              state <= IDLE;
            end else begin
              prod_q <= {bus.mul_hi, bus.mul_lo};
              state  <= FIX;
            end
          end else if (bus.flush) begin
            state <= DRAIN;
          end
        end
        FIX: begin
          if (!bus.flush) begin
            cache_valid  <= 1'b1;
            cache_op     <= op_q;
            cache_rs1    <= rs1_q;
            cache_rs2    <= rs2_q;
            cache_prod   <= prod_fix;
            resp_valid_q <= 1'b1;
            resp_data_q  <= fix_word;
          end
          state <= IDLE;
        end
        DRAIN: begin
          if (bus.mul_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: directed vector table, randomized
// requests against an arithmetic reference, and flush/reset sequences.
module tb_mul_ctrl;
  localparam int W = 32;

  logic Clk = 1'b0;
  logic Reset;

  always #5 Clk = ~Clk;

  mul_ctrl_if #(.WIDTH(W)) bus ();

  mul_ctrl #(.WIDTH(W), .CACHE_EN(1)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  int cyc       = 0;
  int mul_lat   = 2;
  int run_count = 0;
  int rdy_count = 0;
  int ready_cyc = -1;
  int resp_count = 0;
  int resp_cyc  = -1;
  logic [W-1:0] last_data;
  logic [W-1:0] cap_a, cap_b;

  // Bench-side cache model (what a correct controller should remember)
  bit           c_valid = 1'b0;
  logic [1:0]   c_op;
  logic [W-1:0] c_a, c_b;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
    bit           hit;
  } vec_t;

  vec_t vecs[12];

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // RV32M result computed directly from the instruction definitions
  function automatic logic [W-1:0] ref_result(input logic [1:0] op, input logic [W-1:0] a,
                                              input logic [W-1:0] b);
    longint sa, sb, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'b0, b});
    case (op)
      2'b00:   begin p = {32'b0, a} * {32'b0, b}; return p[31:0];  end
      2'b01:   begin p = sa * sb;                 return p[63:32]; end
      2'b10:   begin p = sa * ub;                 return p[63:32]; end
      default: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
    endcase
  endfunction

  function automatic bit model_hit(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    return c_valid && (a == c_a) && (b == c_b) && (op == c_op || op == 2'b00);
  endfunction

  function automatic logic [W-1:0] exp_mag(input logic [W-1:0] x, input bit is_signed);
    if (is_signed && x[W-1]) return -x;
    return x;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0;
      3:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  // Cycle counter
  initial forever begin
    @(posedge Clk);
    cyc = cyc + 1;
  end

  // Behavioural multiplier: unsigned product, mul_lat cycles after the run pulse
  initial begin
    int busy;
    int cnt;
    logic [63:0] p;
    busy = 0;
    cnt  = 0;
    bus.mul_ready = 1'b0;
    bus.mul_hi    = '0;
    bus.mul_lo    = '0;
    forever begin
      @(posedge Clk);
      #1;
      bus.mul_ready = 1'b0;
      if (Reset) begin
        busy = 0;
      end else begin
        if (busy != 0) begin
          cnt--;
          if (cnt == 0) begin
            p = {32'b0, cap_a} * {32'b0, cap_b};
            bus.mul_hi    = p[63:32];
            bus.mul_lo    = p[31:0];
            bus.mul_ready = 1'b1;
            busy          = 0;
            ready_cyc     = cyc;
            rdy_count++;
            check_output("mul_operand_hold", {bus.mul_a, bus.mul_b}, {cap_a, cap_b});
          end
        end
        if (bus.mul_run) begin
          run_count++;
          cap_a = bus.mul_a;
          cap_b = bus.mul_b;
          busy  = 1;
          cnt   = mul_lat;
        end
      end
    end
  end

  // Response monitor
  initial forever begin
    @(posedge Clk);
    #1;
    if (bus.resp_valid) begin
      resp_count++;
      last_data = bus.resp_data;
      resp_cyc  = cyc;
    end
  end

  // Watchdog
  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // One full request: accept, wait for the response, check data, latency and cache use
  task automatic apply_stimulus(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [W-1:0] exp, input bit exp_hit);
    int r0, q0, t, acc_cyc;
    @(posedge Clk);
    #2;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    r0      = run_count;
    q0      = resp_count;
    acc_cyc = cyc;
    #1;
    check_output("req_ready_idle", bus.req_ready, 1);
    @(posedge Clk);
    #2;
    bus.req_valid = 1'b0;
    t = 0;
    while (resp_count == q0 && t < 60) begin
      @(posedge Clk);
      #2;
      t++;
    end
    if (resp_count == q0) begin
      check_output("resp_timeout", 0, 1);
    end else begin
      check_output("resp_data", last_data, exp);
      check_output("mul_run_count", run_count - r0, exp_hit ? 0 : 1);
      if (exp_hit) begin
        check_output("hit_latency", resp_cyc, acc_cyc + 1);
      end else begin
        check_output("miss_latency", resp_cyc, ready_cyc + 2);
        check_output("mul_a_mag", cap_a, exp_mag(a, op != 2'b11));
        check_output("mul_b_mag", cap_b, exp_mag(b, op[1] == 1'b0));
      end
    end
    @(posedge Clk);
    #2;
    check_output("single_resp", resp_count - q0, 1);
    if (!exp_hit) begin
      c_valid = 1'b1;
      c_op    = op;
      c_a     = a;
      c_b     = b;
    end
  endtask

  // Present a request for one cycle; returns in the following cycle
  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge Clk);
    #2;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_rs1   = a;
    bus.req_rs2   = b;
    @(posedge Clk);
    #2;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_run();
    int t;
    t = 0;
    while (!bus.mul_run && t < 20) begin
      @(posedge Clk);
      #2;
      t++;
    end
    check_output("run_seen", bus.mul_run, 1);
  endtask

  initial begin
    int r0, q0, rd0, t, hi_cnt;
    logic [1:0] op;
    logic [W-1:0] a, b;
    bit have_prev;

    vecs[0]  = '{2'b01, 32'hFFFF_FFF6, 32'd12,        32'hFFFF_FFFF, 1'b0};
    vecs[1]  = '{2'b00, 32'hFFFF_FFF6, 32'd12,        32'hFFFF_FF88, 1'b1};
    vecs[2]  = '{2'b11, 32'hFFFF_FFF6, 32'd12,        32'h0000_000B, 1'b0};
    vecs[3]  = '{2'b00, 32'hFFFF_FFF6, 32'd12,        32'hFFFF_FF88, 1'b1};
    vecs[4]  = '{2'b10, 32'hFFFF_FFF6, 32'h8000_0000, 32'hFFFF_FFFB, 1'b0};
    vecs[5]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0};
    vecs[6]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1};
    vecs[7]  = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b1};
    vecs[8]  = '{2'b11, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vecs[9]  = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vecs[11] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

    Reset         = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 2'b00;
    bus.req_rs1   = '0;
    bus.req_rs2   = '0;
    bus.flush     = 1'b0;

    // Reset state
    repeat (3) @(posedge Clk);
    #2;
    check_output("rst_req_ready", bus.req_ready, 0);
    check_output("rst_resp_valid", bus.resp_valid, 0);
    check_output("rst_resp_data", bus.resp_data, 0);
    check_output("rst_mul_run", bus.mul_run, 0);
    check_output("rst_mul_a", bus.mul_a, 0);
    check_output("rst_mul_b", bus.mul_b, 0);
    Reset = 1'b0;
    #1;
    check_output("ready_after_reset", bus.req_ready, 1);

    // Directed vectors
    foreach (vecs[i]) begin
      mul_lat = 1 + (i % 4);
      apply_stimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hit);
    end

    // Randomized requests against the reference model
    have_prev = 1'b0;
    a = '0;
    b = '0;
    for (int n = 0; n < 60; n++) begin
      op = 2'($urandom_range(0, 3));
      if (!(have_prev && $urandom_range(0, 2) == 0)) begin
        a = pick_operand();
        b = pick_operand();
      end
      have_prev = 1'b1;
      mul_lat = $urandom_range(1, 5);
      apply_stimulus(op, a, b, ref_result(op, a, b), model_hit(op, a, b));
    end

    // Establish a known cache entry
    mul_lat = 2;
    apply_stimulus(2'b01, 32'h1357, 32'h2468, ref_result(2'b01, 32'h1357, 32'h2468), 1'b0);

    // Flush in the same cycle as a request that would hit: not accepted
    r0 = run_count;
    q0 = resp_count;
    @(posedge Clk);
    #2;
    bus.req_valid = 1'b1;
    bus.req_op    = 2'b00;
    bus.req_rs1   = 32'h1357;
    bus.req_rs2   = 32'h2468;
    bus.flush     = 1'b1;
    #1;
    check_output("flush_blocks_ready", bus.req_ready, 0);
    @(posedge Clk);
    #2;
    bus.req_valid = 1'b0;
    bus.flush     = 1'b0;
    repeat (4) @(posedge Clk);
    #2;
    check_output("flush_req_no_resp", resp_count - q0, 0);
    check_output("flush_req_no_run", run_count - r0, 0);

    // Flush in START: no run pulse, no response
    r0 = run_count;
    q0 = resp_count;
    issue(2'b11, 32'h1234, 32'h5678);
    bus.flush = 1'b1;
    @(posedge Clk);
    #2;
    bus.flush = 1'b0;
    repeat (4) @(posedge Clk);
    #3;
    check_output("flush_start_no_run", run_count - r0, 0);
    check_output("flush_start_no_resp", resp_count - q0, 0);
    check_output("flush_start_idle", bus.req_ready, 1);

    // Flush coinciding with mul_ready in WAIT: straight back to IDLE
    mul_lat = 3;
    q0 = resp_count;
    issue(2'b00, 32'h11, 32'h22);
    wait_run();
    repeat (3) begin
      @(posedge Clk);
      #2;
    end
    check_output("coincide_mul_ready", bus.mul_ready, 1);
    bus.flush = 1'b1;
    @(posedge Clk);
    #2;
    bus.flush = 1'b0;
    #1;
    check_output("coincide_idle", bus.req_ready, 1);
    repeat (3) @(posedge Clk);
    #2;
    check_output("coincide_no_resp", resp_count - q0, 0);

    // Flushes never invalidated the cached entry
    apply_stimulus(2'b00, 32'h1357, 32'h2468, ref_result(2'b00, 32'h1357, 32'h2468), 1'b1);

    // Flush during WAIT with a late mul_ready: DRAIN keeps req_ready low
    mul_lat = 6;
    q0  = resp_count;
    r0  = run_count;
    rd0 = rdy_count;
    issue(2'b00, 32'd7, 32'd9);
    wait_run();
    bus.flush = 1'b1;
    @(posedge Clk);
    #2;
    bus.flush = 1'b0;
    hi_cnt = 0;
    t = 0;
    while (rdy_count == rd0 && t < 20) begin
      #1;
      if (bus.req_ready) hi_cnt++;
      @(posedge Clk);
      #2;
      t++;
    end
    check_output("drain_mul_ready_seen", rdy_count - rd0, 1);
    #1;
    check_output("drain_ready_low_at_rdy", bus.req_ready, 0);
    check_output("drain_ready_never_high", hi_cnt, 0);
    @(posedge Clk);
    #3;
    check_output("drain_exit_ready", bus.req_ready, 1);
    check_output("drain_no_resp", resp_count - q0, 0);
    check_output("drain_one_run", run_count - r0, 1);
    mul_lat = 2;
    apply_stimulus(2'b00, 32'd3, 32'd5, 32'h0000_000F, model_hit(2'b00, 32'd3, 32'd5));

    // Flush in FIX: no response and no cache write
    mul_lat = 2;
    q0 = resp_count;
    issue(2'b00, 32'h33, 32'h44);
    wait_run();
    repeat (3) begin
      @(posedge Clk);
      #2;
    end
    bus.flush = 1'b1;
    @(posedge Clk);
    #2;
    bus.flush = 1'b0;
    repeat (3) @(posedge Clk);
    #2;
    check_output("flush_fix_no_resp", resp_count - q0, 0);
    apply_stimulus(2'b00, 32'h33, 32'h44, 32'h0000_0D8C, 1'b0);

    // Reset asserted in WAIT
    mul_lat = 8;
    q0 = resp_count;
    r0 = run_count;
    issue(2'b00, 32'h55, 32'h66);
    wait_run();
    Reset = 1'b1;
    @(posedge Clk);
    #2;
    check_output("wait_rst_req_ready", bus.req_ready, 0);
    check_output("wait_rst_resp_valid", bus.resp_valid, 0);
    check_output("wait_rst_resp_data", bus.resp_data, 0);
    check_output("wait_rst_mul_run", bus.mul_run, 0);
    check_output("wait_rst_mul_a", bus.mul_a, 0);
    check_output("wait_rst_mul_b", bus.mul_b, 0);
    Reset   = 1'b0;
    c_valid = 1'b0;
    #1;
    check_output("wait_rst_idle", bus.req_ready, 1);
    repeat (10) @(posedge Clk);
    #2;
    check_output("wait_rst_no_resp", resp_count - q0, 0);
    check_output("wait_rst_one_run", run_count - r0, 1);
    mul_lat = 3;
    apply_stimulus(2'b00, 32'h33, 32'h44, 32'h0000_0D8C, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
